// File: rtl/arbitro_banco_registros_pkg.sv
// Shared types for the register-bank arbiter: operation/state encodings and
// the request payload captured on accept.
package banco_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 3;

  typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    op_e                   write;
    logic [REG_AW_DEF-1:0] reg_idx;
    logic                  size;
    logic                  hl;
    logic                  data_h;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  // Byte access only exists for the first four registers.
  function automatic logic is_legal(input req_t r);
    return r.size || (r.reg_idx <= REG_AW_DEF'(3));
  endfunction

endpackage

// File: rtl/arbitro_banco_registros_if.sv
// One requester port of the register-bank arbiter: request handshake plus
// completion response.
interface arbitro_banco_registros_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              valid;
  logic              ready;
  logic              write;
  logic [REG_AW-1:0] reg_idx;
  logic              size;
  logic              high_low;
  logic              data_h;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output valid, write, reg_idx, size, high_low, data_h, wdata,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, write, reg_idx, size, high_low, data_h, wdata,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/arbitro_banco_registros_rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer moves to the loser of every
// accepted grant so a continuously requesting pair alternates.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;  // 0: req0 preferred on conflict

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= 1'b0;
    else if (advance) ptr <= ~grant[1];
  end

endmodule

// File: rtl/arbitro_banco_registros.sv
// Shares the 8x16 register bank between two requesters, one access in flight,
// fixed-latency read/ack returned to the requester that was granted.
module arbitro_banco_registros
  import banco_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int READ_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  arbitro_banco_registros_if.slave  req0,
  arbitro_banco_registros_if.slave  req1,
  output logic [REG_AW-1:0]         bank_select_reg,
  output logic                      bank_size,
  output logic                      bank_select_high_low,
  output logic                      bank_select_data_h_reg,
  output logic                      bank_read_write,
  output logic [DATA_W-1:0]         bank_wdata,
  input  logic [DATA_W-1:0]         bank_rdata
);

  localparam int HALF = DATA_W / 2;

  state_e                   state;
  req_t                     pay;
  req_t                     req_mux;
  logic                     owner;
  logic [1:0]               valid_v;
  logic [1:0]               grant;
  logic                     accept;
  logic                     legal;
  logic [1:0]               cnt;
  logic [1:0]               rsp_valid_q;
  logic [1:0]               rsp_err_q;
  logic [1:0][DATA_W-1:0]   rsp_rdata_q;
  logic [DATA_W-1:0]        rd_fmt;

  assign valid_v = {req1.valid, req0.valid};

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst     (reset),
    .valid   (valid_v),
    .advance (accept),
    .grant   (grant)
  );

  assign accept = (state == IDLE) && (|grant);

  assign req0.ready = !reset && (state == IDLE) && grant[0];
  assign req1.ready = !reset && (state == IDLE) && grant[1];

  always_comb begin
    if (grant[1]) begin
      req_mux.write   = op_e'(req1.write);
      req_mux.reg_idx = req1.reg_idx;
      req_mux.size    = req1.size;
      req_mux.hl      = req1.high_low;
      req_mux.data_h  = req1.data_h;
      req_mux.wdata   = req1.wdata;
    end else begin
      req_mux.write   = op_e'(req0.write);
      req_mux.reg_idx = req0.reg_idx;
      req_mux.size    = req0.size;
      req_mux.hl      = req0.high_low;
      req_mux.data_h  = req0.data_h;
      req_mux.wdata   = req0.wdata;
    end
  end

  assign legal = is_legal(pay);

  // Bank pins come straight from the payload register so they hold between accesses.
  assign bank_select_reg        = pay.reg_idx;
  assign bank_size              = pay.size;
  assign bank_select_high_low   = pay.hl;
  assign bank_select_data_h_reg = pay.data_h;
  assign bank_wdata             = pay.wdata;
  assign bank_read_write        = (state != IDLE) && (pay.write == OP_WRITE) && legal;

  // 8-bit reads return the selected byte zero-extended.
  always_comb begin
    rd_fmt = bank_rdata;
    if (!pay.size)
      rd_fmt = pay.hl ? {{HALF{1'b0}}, bank_rdata[DATA_W-1:HALF]}
                      : {{HALF{1'b0}}, bank_rdata[HALF-1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pay         <= '0;
      owner       <= 1'b0;
      cnt         <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      case (state)
        IDLE: if (accept) begin
          pay   <= req_mux;
          owner <= grant[1];
          state <= ISSUE;
        end
        ISSUE: if (pay.write == OP_WRITE || !legal) begin
          state              <= IDLE;
          rsp_valid_q[owner] <= 1'b1;
          rsp_err_q[owner]   <= !legal;
        end else begin
          state <= WAIT;
          cnt   <= 2'(READ_LAT - 1);
        end
        WAIT: if (cnt == 2'd0) begin
          state              <= RESP;
          rsp_valid_q[owner] <= 1'b1;
          rsp_rdata_q[owner] <= rd_fmt;
        end else begin
          cnt <= cnt - 2'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req0.rsp_valid = rsp_valid_q[0];
  assign req0.rsp_err   = rsp_err_q[0];
  assign req0.rsp_rdata = rsp_rdata_q[0];
  assign req1.rsp_valid = rsp_valid_q[1];
  assign req1.rsp_err   = rsp_err_q[1];
  assign req1.rsp_rdata = rsp_rdata_q[1];

endmodule
